// File: rtl/alarm_clock_pkg.sv
// Shared definitions for the alarm-clock datapath: field widths, mode codes,
// button identifiers and a wrap-around increment helper.
package alarm_clock_pkg;

    localparam int HR_W   = 5;
    localparam int MIN_W  = 6;
    localparam int MODE_W = 3;

    localparam logic [MODE_W-1:0] RUN         = 3'd0;
    localparam logic [MODE_W-1:0] ADJ_CLK_HR  = 3'd1;
    localparam logic [MODE_W-1:0] ADJ_CLK_MIN = 3'd2;
    localparam logic [MODE_W-1:0] ADJ_ALM_HR  = 3'd3;
    localparam logic [MODE_W-1:0] ADJ_ALM_MIN = 3'd4;

    typedef enum logic [MODE_W-1:0] {
        M_RUN         = RUN,
        M_ADJ_CLK_HR  = ADJ_CLK_HR,
        M_ADJ_CLK_MIN = ADJ_CLK_MIN,
        M_ADJ_ALM_HR  = ADJ_ALM_HR,
        M_ADJ_ALM_MIN = ADJ_ALM_MIN
    } mode_e;

    typedef enum logic [2:0] {
        BTN_NONE,
        BTN_C,
        BTN_R,
        BTN_L,
        BTN_U,
        BTN_D
    } btn_e;

    function automatic int unsigned wrap_inc(input int unsigned v, input int unsigned max_v);
        return (v >= max_v) ? 0 : v + 1;
    endfunction

endpackage

// File: rtl/wrap_counter.sv
// Up/down counter over 0..MAX that wraps in both directions. carry is a
// combinational pulse on an inc that wraps MAX -> 0, so it can cascade same-edge.
module wrap_counter #(
    parameter int MAX = 59,
    parameter int W   = 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] value,
    output logic         carry
);

    logic [W-1:0] value_q;
    logic [W-1:0] value_d;
    logic         at_max;
    logic         at_zero;

    assign at_max  = (value_q == W'(MAX));
    assign at_zero = (value_q == '0);

    always_comb begin
        value_d = value_q;
        if (inc) begin
            value_d = at_max ? '0 : value_q + W'(1);
        end else if (dec) begin
            value_d = at_zero ? W'(MAX) : value_q - W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

    assign value = value_q;
    assign carry = inc && at_max;

endmodule

// File: rtl/time_set_ctrl.sv
// Alarm-clock mode controller: button priority, mode FSM, alarm ring and the
// inc/dec steering into the clock and alarm hour/minute counters.
module time_set_ctrl
    import alarm_clock_pkg::*;
#(
    parameter int HR_MAX  = 23,
    parameter int MIN_MAX = 59
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tick_min,
    input  logic              btn_c,
    input  logic              btn_u,
    input  logic              btn_d,
    input  logic              btn_l,
    input  logic              btn_r,
    input  logic              alarm_en,
    output logic [HR_W-1:0]   clk_hr,
    output logic [MIN_W-1:0]  clk_min,
    output logic [HR_W-1:0]   alm_hr,
    output logic [MIN_W-1:0]  alm_min,
    output logic [MODE_W-1:0] mode,
    output logic              alarm_ring
);

    mode_e              mode_q, mode_d;
    logic               ring_q, ring_d;
    btn_e               btn;
    logic               clk_frozen;
    logic               tick_adv;
    logic               ring_set;
    logic               ring_clr;
    logic [HR_W-1:0]    nxt_hr;
    logic [MIN_W-1:0]   nxt_min;

    // Index 0 = clock, index 1 = alarm.
    logic [1:0]         hr_inc, hr_dec, min_inc, min_dec;
    logic [1:0]         hr_carry, min_carry;
    logic [HR_W-1:0]    hr_val  [2];
    logic [MIN_W-1:0]   min_val [2];

    always_comb begin
        btn = BTN_NONE;
        if (btn_c)      btn = BTN_C;
        else if (btn_r) btn = BTN_R;
        else if (btn_l) btn = BTN_L;
        else if (btn_u) btn = BTN_U;
        else if (btn_d) btn = BTN_D;
    end

    assign clk_frozen = (mode_q == M_ADJ_CLK_HR) || (mode_q == M_ADJ_CLK_MIN);
    assign tick_adv   = tick_min && !clk_frozen;

    // Hour carry only follows the tick path so manual minute edits never spill.
    assign min_inc[0] = ((mode_q == M_ADJ_CLK_MIN) && (btn == BTN_U)) || tick_adv;
    assign min_dec[0] = (mode_q == M_ADJ_CLK_MIN) && (btn == BTN_D);
    assign hr_inc[0]  = ((mode_q == M_ADJ_CLK_HR) && (btn == BTN_U)) || (tick_adv && min_carry[0]);
    assign hr_dec[0]  = (mode_q == M_ADJ_CLK_HR) && (btn == BTN_D);
    assign min_inc[1] = (mode_q == M_ADJ_ALM_MIN) && (btn == BTN_U);
    assign min_dec[1] = (mode_q == M_ADJ_ALM_MIN) && (btn == BTN_D);
    assign hr_inc[1]  = (mode_q == M_ADJ_ALM_HR) && (btn == BTN_U);
    assign hr_dec[1]  = (mode_q == M_ADJ_ALM_HR) && (btn == BTN_D);

    for (genvar gi = 0; gi < 2; gi++) begin : g_time
        wrap_counter #(.MAX(HR_MAX), .W(HR_W)) u_hr (
            .clk   (clk),
            .rst   (rst),
            .inc   (hr_inc[gi]),
            .dec   (hr_dec[gi]),
            .value (hr_val[gi]),
            .carry (hr_carry[gi])
        );
        wrap_counter #(.MAX(MIN_MAX), .W(MIN_W)) u_min (
            .clk   (clk),
            .rst   (rst),
            .inc   (min_inc[gi]),
            .dec   (min_dec[gi]),
            .value (min_val[gi]),
            .carry (min_carry[gi])
        );
    end

    logic unused_carries;
    assign unused_carries = ^{hr_carry, min_carry[1]};

    // Clock time as it will read after a tick, for the alarm match.
    always_comb begin
        nxt_min = MIN_W'(wrap_inc(32'(min_val[0]), MIN_MAX));
        nxt_hr  = hr_val[0];
        if (min_val[0] == MIN_W'(MIN_MAX)) begin
            nxt_hr = HR_W'(wrap_inc(32'(hr_val[0]), HR_MAX));
        end
    end

    assign ring_set = tick_adv && alarm_en && (nxt_hr == hr_val[1]) && (nxt_min == min_val[1]);
    assign ring_clr = btn_c || (tick_min && ring_q) || !alarm_en;
    assign ring_d   = !ring_clr && (ring_q || ring_set);

    always_comb begin
        mode_d = mode_q;
        case (mode_q)
            M_RUN: begin
                if ((btn == BTN_C) && !ring_q) mode_d = M_ADJ_CLK_HR;
            end
            M_ADJ_CLK_HR: begin
                if (btn == BTN_C)      mode_d = M_RUN;
                else if (btn == BTN_R) mode_d = M_ADJ_CLK_MIN;
                else if (btn == BTN_L) mode_d = M_ADJ_ALM_MIN;
            end
            M_ADJ_CLK_MIN: begin
                if (btn == BTN_C)      mode_d = M_RUN;
                else if (btn == BTN_R) mode_d = M_ADJ_ALM_HR;
                else if (btn == BTN_L) mode_d = M_ADJ_CLK_HR;
            end
            M_ADJ_ALM_HR: begin
                if (btn == BTN_C)      mode_d = M_RUN;
                else if (btn == BTN_R) mode_d = M_ADJ_ALM_MIN;
                else if (btn == BTN_L) mode_d = M_ADJ_CLK_MIN;
            end
            M_ADJ_ALM_MIN: begin
                if (btn == BTN_C)      mode_d = M_RUN;
                else if (btn == BTN_R) mode_d = M_ADJ_CLK_HR;
                else if (btn == BTN_L) mode_d = M_ADJ_ALM_HR;
            end
            default: mode_d = M_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q <= M_RUN;
            ring_q <= 1'b0;
        end else begin
            mode_q <= mode_d;
            ring_q <= ring_d;
        end
    end

    assign clk_hr     = hr_val[0];
    assign clk_min    = min_val[0];
    assign alm_hr     = hr_val[1];
    assign alm_min    = min_val[1];
    assign mode       = mode_q;
    assign alarm_ring = ring_q;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Bench for time_set_ctrl: directed scenarios followed by random pulses, all
// checked against a minutes-of-day reference model.
module tb_time_set_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       tick_min = 1'b0;
    logic       btn_c = 1'b0, btn_u = 1'b0, btn_d = 1'b0, btn_l = 1'b0, btn_r = 1'b0;
    logic       alarm_en = 1'b0;
    logic [4:0] clk_hr, alm_hr;
    logic [5:0] clk_min, alm_min;
    logic [2:0] mode;
    logic       alarm_ring;

    int checks = 0;
    int failures = 0;

    // Reference model: clock as minutes since midnight, alarm as h/m.
    int m_t = 0, m_ah = 0, m_am = 0, m_mode = 0;
    bit m_ring = 0;

    time_set_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .tick_min   (tick_min),
        .btn_c      (btn_c),
        .btn_u      (btn_u),
        .btn_d      (btn_d),
        .btn_l      (btn_l),
        .btn_r      (btn_r),
        .alarm_en   (alarm_en),
        .clk_hr     (clk_hr),
        .clk_min    (clk_min),
        .alm_hr     (alm_hr),
        .alm_min    (alm_min),
        .mode       (mode),
        .alarm_ring (alarm_ring)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_step(input bit rs, tk, c, r, l, u, d);
        int  w, delta;
        bit  frozen, st, cl;
        if (rs) begin
            m_t = 0; m_ah = 0; m_am = 0; m_mode = 0; m_ring = 0;
            return;
        end
        w = c ? 1 : r ? 2 : l ? 3 : u ? 4 : d ? 5 : 0;
        frozen = (m_mode == 1) || (m_mode == 2);
        st = tk && !frozen && alarm_en && (((m_t + 1) % 1440) == m_ah * 60 + m_am);
        cl = c || (tk && m_ring) || !alarm_en;
        if (tk && !frozen) m_t = (m_t + 1) % 1440;
        if (m_mode == 0) begin
            if (w == 1 && !m_ring) m_mode = 1;
        end else begin
            delta = (w == 4) ? 1 : -1;
            case (w)
                1: m_mode = 0;
                2: m_mode = m_mode % 4 + 1;
                3: m_mode = (m_mode + 2) % 4 + 1;
                4, 5: case (m_mode)
                    1: m_t = ((m_t / 60 + delta + 24) % 24) * 60 + m_t % 60;
                    2: m_t = (m_t / 60) * 60 + (m_t % 60 + delta + 60) % 60;
                    3: m_ah = (m_ah + delta + 24) % 24;
                    default: m_am = (m_am + delta + 60) % 60;
                endcase
                default: ;
            endcase
        end
        m_ring = !cl && (m_ring || st);
    endtask

    // One clock: drive on the falling edge, check #1 after the rising edge.
    task automatic cyc(input bit rs, tk, c, r, l, u, d);
        @(negedge clk);
        rst = rs; tick_min = tk; btn_c = c; btn_r = r; btn_l = l; btn_u = u; btn_d = d;
        model_step(rs, tk, c, r, l, u, d);
        @(posedge clk);
        #1;
        $display("cyc rst=%0b tick=%0b c%0b r%0b l%0b u%0b d%0b en=%0b -> %02d:%02d alm %02d:%02d mode=%0d ring=%0b",
                 rs, tk, c, r, l, u, d, alarm_en, clk_hr, clk_min, alm_hr, alm_min, mode, alarm_ring);
        chk("clk_hr",  32'(clk_hr),     32'(m_t / 60));
        chk("clk_min", 32'(clk_min),    32'(m_t % 60));
        chk("alm_hr",  32'(alm_hr),     32'(m_ah));
        chk("alm_min", 32'(alm_min),    32'(m_am));
        chk("mode",    32'(mode),       32'(m_mode));
        chk("ring",    32'(alarm_ring), 32'(m_ring));
    endtask

    task automatic tick();         cyc(0, 1, 0, 0, 0, 0, 0); endtask
    task automatic press_c();      cyc(0, 0, 1, 0, 0, 0, 0); endtask
    task automatic press_r();      cyc(0, 0, 0, 1, 0, 0, 0); endtask
    task automatic press_l();      cyc(0, 0, 0, 0, 1, 0, 0); endtask
    task automatic press_u(int n); for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 1, 0); endtask
    task automatic press_d(int n); for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 1); endtask

    initial begin
        // Reset state
        cyc(1, 0, 0, 0, 0, 0, 0);
        chk("rst_mode", 32'(mode), 0);
        chk("rst_clk",  {clk_hr, clk_min}, 0);

        // 60 ticks: 00:00 -> 01:00
        for (int i = 0; i < 60; i++) tick();
        chk("t60_hr", 32'(clk_hr), 1);
        chk("t60_min", 32'(clk_min), 0);

        // Hour wrap down, minute wrap up without carry
        press_c(); press_d(2);
        chk("hr_wrap_dn", 32'(clk_hr), 23);
        press_r(); press_d(1);
        chk("min_wrap_dn", 32'(clk_min), 59);
        press_u(1);
        chk("min_wrap_up", 32'(clk_min), 0);
        chk("no_carry_hr", 32'(clk_hr), 23);
        press_d(1); press_c();

        // 23:59 + tick -> 00:00
        tick();
        chk("midnight_hr", 32'(clk_hr), 0);
        chk("midnight_min", 32'(clk_min), 0);
        chk("midnight_mode", 32'(mode), 0);

        // Clock frozen in ADJ_CLK_MIN
        press_c(); press_r();
        for (int i = 0; i < 3; i++) tick();
        chk("frozen_min", 32'(clk_min), 0);
        press_l(); press_l();
        chk("l_from_hr", 32'(mode), 4);
        press_l();

        // Same-cycle C+U in ADJ_ALM_HR, then U+D
        cyc(0, 0, 1, 0, 0, 1, 0);
        chk("cu_mode", 32'(mode), 0);
        chk("cu_alm_hr", 32'(alm_hr), 0);
        press_c(); press_r(); press_r();
        cyc(0, 0, 0, 0, 0, 1, 1);
        chk("ud_alm_hr", 32'(alm_hr), 1);

        // Alarm 07:30, clock 07:29
        press_u(6); press_r(); press_u(30);
        press_l(); press_l(); press_l();
        press_u(7); press_r(); press_u(29); press_c();
        alarm_en = 1'b1;
        tick();
        chk("ring_set", 32'(alarm_ring), 1);
        press_c();
        chk("ring_silenced", 32'(alarm_ring), 0);
        chk("ring_mode_run", 32'(mode), 0);

        // Same with alarm disabled
        alarm_en = 1'b0;
        press_c(); press_r(); press_d(1); press_c();
        tick();
        chk("ring_disabled", 32'(alarm_ring), 0);

        // Ring then reset
        alarm_en = 1'b1;
        press_c(); press_r(); press_d(1); press_c();
        tick();
        chk("ring_set2", 32'(alarm_ring), 1);
        cyc(1, 0, 0, 0, 0, 0, 0);
        chk("rst_ring", 32'(alarm_ring), 0);
        chk("rst_alarm", {alm_hr, alm_min}, 0);

        // Ring at 00:00, cleared by the next tick; manual match never rings
        press_c(); press_d(1); press_r(); press_d(1); press_c();
        tick();
        chk("ring_midnight", 32'(alarm_ring), 1);
        tick();
        chk("ring_tick_clr", 32'(alarm_ring), 0);
        press_c(); press_r(); press_d(1);
        chk("manual_match", 32'(alarm_ring), 0);
        press_c();

        // Randomized pulses against the model
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 29) == 0) alarm_en = ~alarm_en;
            cyc($urandom_range(0, 149) == 0, $urandom_range(0, 2) == 0,
                $urandom_range(0, 6) == 0, $urandom_range(0, 5) == 0,
                $urandom_range(0, 5) == 0, $urandom_range(0, 3) == 0,
                $urandom_range(0, 4) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
